// File: rtl/multi_bank_select_ctrl.sv
// Multi-bank request steering: decodes the top address bits into an MSB-first
// one-hot bank enable and stalls requests whose target bank is still busy.
module multi_bank_select_ctrl #(
    parameter int  ADDR_WIDTH  = 6,
    parameter int  NUM_BANKS   = 4,
    parameter int  BUSY_CYCLES = 2,
    localparam int SEL_W       = $clog2(NUM_BANKS),
    localparam int OFF_W       = ADDR_WIDTH - SEL_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_wr,
    output logic [NUM_BANKS-1:0]  o_bank_en,
    output logic [OFF_W-1:0]      o_bank_addr,
    output logic                  o_bank_wr,
    output logic [NUM_BANKS-1:0]  o_bank_busy,
    output logic                  o_conflict
);
    localparam int CNT_W = $clog2(BUSY_CYCLES + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t BUSY_LOAD = cnt_t'(BUSY_CYCLES);

    logic [SEL_W-1:0]     bank_idx_s;
    logic [NUM_BANKS-1:0] sel_onehot_s;
    logic                 target_busy_s;
    logic                 accept_s;
    logic [NUM_BANKS-1:0] busy_nxt_s;
    cnt_t                 cnt_nxt_s [NUM_BANKS];
    cnt_t                 cnt_r     [NUM_BANKS];

    // Bank decode, stall detection and acceptance
    always_comb begin
        bank_idx_s = i_addr[ADDR_WIDTH-1 -: SEL_W];
        for (int j = 0; j < NUM_BANKS; j++) begin
            sel_onehot_s[NUM_BANKS-1-j] = (bank_idx_s == SEL_W'(j));
        end
        target_busy_s = |(sel_onehot_s & o_bank_busy);
        o_req_ready   = i_rst_n & ~target_busy_s;
        o_conflict    = i_req_valid & target_busy_s;
        accept_s      = i_req_valid & o_req_ready;
    end

    // Per-bank busy counters: a new access reloads, otherwise count down to zero
    always_comb begin
        for (int j = 0; j < NUM_BANKS; j++) begin
            if (accept_s && sel_onehot_s[NUM_BANKS-1-j]) begin
                cnt_nxt_s[j] = BUSY_LOAD;
            end else if (cnt_r[j] != '0) begin
                cnt_nxt_s[j] = cnt_r[j] - cnt_t'(1'b1);
            end else begin
                cnt_nxt_s[j] = '0;
            end
            busy_nxt_s[NUM_BANKS-1-j] = (cnt_nxt_s[j] != '0);
        end
    end

    // Registered bank-side outputs and counter state; reset beats acceptance
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_bank_en   <= '0;
            o_bank_addr <= '0;
            o_bank_wr   <= 1'b0;
            o_bank_busy <= '0;
            cnt_r       <= '{default: '0};
        end else begin
            o_bank_en   <= accept_s ? sel_onehot_s : '0;
            o_bank_busy <= busy_nxt_s;
            cnt_r       <= cnt_nxt_s;
            if (accept_s) begin
                o_bank_addr <= i_addr[OFF_W-1:0];
                o_bank_wr   <= i_wr;
            end else begin
                o_bank_addr <= o_bank_addr;
                o_bank_wr   <= o_bank_wr;
            end
        end
    end

endmodule

// File: tb/tb_multi_bank_select_ctrl.sv
// Scoreboard bench for multi_bank_select_ctrl: default 4-bank instance plus an
// 8-bank instance for the wider decode.
module tb_multi_bank_select_ctrl;
    localparam int AW  = 6;
    localparam int NB  = 4;
    localparam int BC  = 2;
    localparam int SW  = 2;
    localparam int IAW = AW - SW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, req_valid, req_ready, wr, bank_wr, conflict;
    logic [AW-1:0]  addr;
    logic [NB-1:0]  bank_en, bank_busy;
    logic [IAW-1:0] bank_addr;

    logic       rst8_n, valid8, ready8, wr8, bank_wr8, conflict8;
    logic [7:0] addr8, en8, busy8;
    logic [4:0] baddr8;

    multi_bank_select_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_addr(addr), .i_wr(wr), .o_bank_en(bank_en), .o_bank_addr(bank_addr),
        .o_bank_wr(bank_wr), .o_bank_busy(bank_busy), .o_conflict(conflict)
    );

    multi_bank_select_ctrl #(.ADDR_WIDTH(8), .NUM_BANKS(8), .BUSY_CYCLES(2)) dut8 (
        .i_clk(clk), .i_rst_n(rst8_n), .i_req_valid(valid8), .o_req_ready(ready8),
        .i_addr(addr8), .i_wr(wr8), .o_bank_en(en8), .o_bank_addr(baddr8),
        .o_bank_wr(bank_wr8), .o_bank_busy(busy8), .o_conflict(conflict8)
    );

    typedef struct packed {
        logic [NB-1:0]  en;
        logic [IAW-1:0] addr;
        logic           wr;
    } exp_t;

    exp_t           exp_q[$];
    int             exp_cnt[NB];
    logic [IAW-1:0] last_addr;
    logic           last_wr;
    int             n_checks = 0;
    int             n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] onehot(input int k);
        logic [NB-1:0] r;
        r = '0;
        r[NB-1-k] = 1'b1;
        return r;
    endfunction

    function automatic logic [NB-1:0] model_busy();
        logic [NB-1:0] b;
        b = '0;
        for (int j = 0; j < NB; j++) b[NB-1-j] = (exp_cnt[j] != 0);
        return b;
    endfunction

    // One clock of traffic: check handshake, push expectation, advance model, check outputs
    task automatic step(input logic v, input logic [AW-1:0] a, input logic w, output bit acc);
        int   k;
        logic exp_rdy;
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1; req_valid = v; addr = a; wr = w;
        #1;
        k       = int'(a[AW-1 -: SW]);
        exp_rdy = (exp_cnt[k] == 0);
        check_val("ready", {31'd0, req_ready}, {31'd0, exp_rdy});
        check_val("conflict", {31'd0, conflict}, {31'd0, v & ~exp_rdy});
        acc = v & exp_rdy;
        if (acc) begin
            e.en = onehot(k); e.addr = a[IAW-1:0]; e.wr = w;
            exp_q.push_back(e);
        end
        @(posedge clk);
        for (int j = 0; j < NB; j++) begin
            if (acc && j == k) exp_cnt[j] = BC;
            else if (exp_cnt[j] > 0) exp_cnt[j]--;
        end
        #1;
        if (acc) begin
            e = exp_q.pop_front();
            check_val("bank_en", 32'(bank_en), 32'(e.en));
            check_val("bank_addr", 32'(bank_addr), 32'(e.addr));
            check_val("bank_wr", {31'd0, bank_wr}, {31'd0, e.wr});
            last_addr = e.addr; last_wr = e.wr;
        end else begin
            check_val("en_idle", 32'(bank_en), 32'd0);
            check_val("addr_hold", 32'(bank_addr), 32'(last_addr));
            check_val("wr_hold", {31'd0, bank_wr}, {31'd0, last_wr});
        end
        check_val("busy", 32'(bank_busy), 32'(model_busy()));
    endtask

    // One clock with reset asserted, possibly alongside a valid request
    task automatic rst_cycle(input logic v, input logic [AW-1:0] a);
        @(negedge clk);
        rst_n = 1'b0; req_valid = v; addr = a; wr = 1'b1;
        #1;
        check_val("rst_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        for (int j = 0; j < NB; j++) exp_cnt[j] = 0;
        last_addr = '0; last_wr = 1'b0;
        #1;
        check_val("rst_en", 32'(bank_en), 32'd0);
        check_val("rst_addr", 32'(bank_addr), 32'd0);
        check_val("rst_wr", {31'd0, bank_wr}, 32'd0);
        check_val("rst_busy", 32'(bank_busy), 32'd0);
    endtask

    initial begin
        bit            acc, held;
        int            stalls;
        logic          rv, rw;
        logic [AW-1:0] ra;

        rst_n = 1'b0; req_valid = 1'b0; addr = '0; wr = 1'b0;
        rst8_n = 1'b0; valid8 = 1'b0; addr8 = '0; wr8 = 1'b0;
        for (int j = 0; j < NB; j++) exp_cnt[j] = 0;
        last_addr = '0; last_wr = 1'b0;

        // Reset held three cycles, then idle after release
        for (int i = 0; i < 3; i++) rst_cycle(1'b0, 6'b00_0000);
        step(1'b0, 6'b00_0000, 1'b0, acc);

        // Single write to bank 0, busy for two cycles
        step(1'b1, 6'b00_0101, 1'b1, acc);
        check_val("r033_en", 32'(bank_en), 32'h8);
        check_val("r033_addr", 32'(bank_addr), 32'h5);
        check_val("r033_busy0", 32'(bank_busy), 32'h8);
        step(1'b0, 6'b00_0000, 1'b0, acc);
        check_val("r033_busy1", 32'(bank_busy), 32'h8);
        step(1'b0, 6'b00_0000, 1'b0, acc);
        check_val("r033_busy2", 32'(bank_busy), 32'h0);

        // Back-to-back requests to distinct banks
        step(1'b1, 6'b01_0000, 1'b0, acc);
        check_val("r034_en1", 32'(bank_en), 32'h4);
        step(1'b1, 6'b10_0001, 1'b1, acc);
        check_val("r034_en2", 32'(bank_en), 32'h2);
        step(1'b1, 6'b11_0010, 1'b0, acc);
        check_val("r034_en3", 32'(bank_en), 32'h1);
        for (int i = 0; i < 3; i++) step(1'b0, 6'b00_0000, 1'b0, acc);

        // Same-bank conflict: held request must stall exactly two cycles
        step(1'b1, 6'b10_0000, 1'b0, acc);
        stalls = 0;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            step(1'b1, 6'b10_0011, 1'b1, acc);
            if (!acc) stalls++;
        end
        check_val("r035_stalls", 32'(stalls), 32'd2);
        check_val("r035_en", 32'(bank_en), 32'h2);
        check_val("r035_addr", 32'(bank_addr), 32'h3);
        for (int i = 0; i < 3; i++) step(1'b0, 6'b00_0000, 1'b0, acc);

        // Reset right after a bank-0 access clears busy; reset also blocks acceptance
        step(1'b1, 6'b00_0001, 1'b0, acc);
        rst_cycle(1'b1, 6'b00_0010);
        step(1'b1, 6'b00_0011, 1'b1, acc);
        check_val("r036_acc", {31'd0, acc}, 32'd1);
        check_val("r036_en", 32'(bank_en), 32'h8);

        // Random traffic; a stalled requester holds its address and write flag
        held = 1'b0;
        rv = 1'b0; ra = '0; rw = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!held) begin
                rv = ($urandom_range(0, 3) != 0);
                ra = AW'($urandom);
                rw = 1'($urandom);
            end
            step(rv, ra, rw, acc);
            held = rv && !acc;
        end
        check_val("q_empty", 32'(exp_q.size()), 32'd0);

        // Eight-bank instance: highest bank index lands on enable bit 0
        @(negedge clk);
        rst8_n = 1'b1; valid8 = 1'b1; addr8 = 8'b111_00101; wr8 = 1'b0;
        #1;
        check_val("r037_ready", {31'd0, ready8}, 32'd1);
        @(posedge clk);
        #1;
        check_val("r037_en", 32'(en8), 32'h01);
        check_val("r037_addr", 32'(baddr8), 32'h05);
        @(negedge clk);
        valid8 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_bank_select_ctrl.md
MULTI_BANK_SELECT_CTRL -- requirements
Module: multi_bank_select_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6: full input address width.
REQ-002 SHALL have parameter NUM_BANKS, default 4: bank count, power of 2, at least 2.
REQ-003 SHALL have parameter BUSY_CYCLES, default 2: cycles a bank stays busy after an access, at least 1.
REQ-004 SHALL derive localparam SEL_W = log2(NUM_BANKS) and require ADDR_WIDTH > SEL_W.
REQ-005 SHALL have one clock and a synchronous, active-low reset; ports i_clk and i_rst_n.
REQ-006 i_clk  input  1  clock; all state updates on the rising edge.
REQ-007 i_rst_n  input  1  synchronous active-low reset.
REQ-008 i_req_valid  input  1  request present.
REQ-009 o_req_ready  output  1  request can be accepted this cycle.
REQ-010 i_addr  input  ADDR_WIDTH  request address; the top SEL_W bits are the bank index.
REQ-011 i_wr  input  1  1 = write, 0 = read.
REQ-012 o_bank_en  output  NUM_BANKS  registered one-hot bank enable.
REQ-013 o_bank_addr  output  ADDR_WIDTH-SEL_W  registered in-bank address.
REQ-014 o_bank_wr  output  1  registered write flag.
REQ-015 o_bank_busy  output  NUM_BANKS  per-bank busy flags.
REQ-016 o_conflict  output  1  request stalled by a busy target bank.

Function
REQ-017 Bank index k SHALL be i_addr[ADDR_WIDTH-1 -: SEL_W].
- k = 0 selects o_bank_en[NUM_BANKS-1]; k = NUM_BANKS-1 selects o_bank_en[0] (MSB-first one-hot).
REQ-018 o_req_ready SHALL be combinational: ~o_bank_busy[k] while i_rst_n = 1, and 0 while i_rst_n = 0.
REQ-019 A request SHALL be accepted when i_req_valid & o_req_ready at a rising edge.
REQ-020 On acceptance at edge t, from t until the next edge:
- o_bank_en SHALL be the one-hot for k;
- o_bank_addr SHALL be i_addr[ADDR_WIDTH-SEL_W-1:0];
- o_bank_wr SHALL be i_wr.
- Latency is 1 cycle.
REQ-021 o_bank_en SHALL be all-zero in any cycle that follows an edge with no acceptance.
- o_bank_addr and o_bank_wr SHALL hold their last values.
REQ-022 Each bank SHALL have a down-counter, 0..BUSY_CYCLES.
- Loaded with BUSY_CYCLES on acceptance to that bank.
- Otherwise decrements by 1 per cycle when nonzero; saturates at 0.
REQ-023 o_bank_busy[j] SHALL be 1 when bank j's counter is nonzero; bit order matches o_bank_en.
REQ-024 Counter load SHALL take priority over decrement; load and decrement never occur together on the same bank.
REQ-025 Requests to different banks SHALL be acceptable on consecutive cycles (one per cycle, no bubble).
REQ-026 After acceptance to bank j at edge t, a further request to bank j SHALL first be accepted at edge t+BUSY_CYCLES+1.
REQ-027 o_conflict SHALL equal i_req_valid & o_bank_busy[k] (combinational).
- Requester holds i_addr and i_wr stable while stalled.
REQ-028 Idle cycles (i_req_valid = 0) SHALL NOT alter o_bank_en beyond REQ-021; counters continue decrementing.

Reset
REQ-029 While i_rst_n = 0 at an edge, the following SHALL be 0 after that edge: o_bank_en, o_bank_addr, o_bank_wr, o_bank_busy, and all counters.
REQ-030 Reset SHALL override an acceptance in the same cycle; no enable is issued.
REQ-031 Reset mid-operation SHALL discard all busy state.
- The first cycle after release, every bank is ready.

Verification
REQ-032 Defaults, reset held 3 cycles -> all outputs 0, o_req_ready = 0; after release, o_req_ready = 1 and o_conflict = 0.
REQ-033 Defaults, valid with i_addr = 6'b00_0101, i_wr = 1 -> next cycle o_bank_en = 4'b1000, o_bank_addr = 4'b0101, o_bank_wr = 1, o_bank_busy = 4'b1000 for 2 cycles.
REQ-034 Defaults, consecutive addresses 6'b01_0000, 6'b10_0001, 6'b11_0010 -> o_bank_en = 0100, 0010, 0001 on consecutive cycles, no stall.
REQ-035 Defaults, 6'b10_0000 then 6'b10_0011 held valid -> second request has o_req_ready = 0 and o_conflict = 1 for 2 cycles, is accepted at edge t+3, and o_bank_en = 4'b0010 with o_bank_addr = 4'b0011.
REQ-036 Defaults, reset asserted one cycle after acceptance to bank 0 -> o_bank_busy = 0 after the reset edge; bank 0 accepts the first cycle after release.
REQ-037 NUM_BANKS = 8, ADDR_WIDTH = 8, valid with i_addr = 8'b111_00101 -> o_bank_en = 8'b0000_0001, o_bank_addr = 5'b00101.
